id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline stage sitting directly upstream of the ALU in the 5-stage RISC-V core.
- Registers decoded operands and control from ID, then drives SrcA, SrcB and Operation for the ALU.
- Resolves EX-stage data hazards by forwarding from the EX/MEM and MEM/WB stages.
- Detects load-use hazards, stalls IF/ID and inserts a bubble; accepts a flush on a taken branch.

Parameters:
- DATA_WIDTH, 32, operand/result width
- OPCODE_LENGTH, 4, ALU operation code width
- REG_ADDR_WIDTH, 5, register index width

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- id_valid  in  1  ID holds a real instruction
- id_pc  in  DATA_WIDTH  PC of ID instruction
- id_rs1_data, id_rs2_data  in  DATA_WIDTH  register-file read data
- id_imm  in  DATA_WIDTH  sign-extended immediate
- id_rs1, id_rs2, id_rd  in  REG_ADDR_WIDTH  register indices
- id_alu_op  in  OPCODE_LENGTH  ALU operation code
- id_a_sel  in  1  0=rs1, 1=PC for SrcA
- id_b_sel  in  1  0=rs2, 1=imm for SrcB
- id_reg_write, id_mem_read, id_mem_write  in  1  control bits
- flush  in  1  taken branch/jump; kill the instruction entering EX
- mem_rd  in  REG_ADDR_WIDTH; mem_reg_write  in 1; mem_result  in DATA_WIDTH  EX/MEM forwarding source
- wb_rd  in  REG_ADDR_WIDTH; wb_reg_write  in 1; wb_result  in DATA_WIDTH  MEM/WB forwarding source
- stall  out  1  freeze PC and IF/ID (combinational)
- SrcA, SrcB  out  DATA_WIDTH  ALU operands (combinational from EX regs + forwarding)
- Operation  out  OPCODE_LENGTH  ALU operation
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write  out  1  EX control
- ex_rd  out  REG_ADDR_WIDTH; ex_pc  out DATA_WIDTH; ex_store_data  out DATA_WIDTH (forwarded rs2)

Behaviour:
- Reset (async, any time): all EX registers = 0. Consequences: ex_valid=0, all control bits 0, Operation=0000 (AND), SrcA=SrcB=0, stall=0. A reset mid-stall drops the stalled instruction with no partial update.
- Load-use detect (comb): stall=1 iff ex_valid & ex_mem_read & ex_rd!=0 & id_valid & (ex_rd==id_rs1 | ex_rd==id_rs2). rs2 is compared even for I-type; a false stall is permitted.
- Register update priority per edge: reset > flush > stall > normal.
  - flush: load bubble (valid and all control = 0, data don't-care→0).
  - stall: load bubble; ID holds its instruction externally and re-presents it next cycle.
  - normal: capture all id_* fields, ex_valid=id_valid. When id_valid=0, control bits are captured as 0.
- Flush and stall in the same cycle: a bubble is loaded. stall still reflects the comb equation; the consumer ORs it with flush.
- Forwarding (comb, per operand, using the EX-registered rs1/rs2):
  - Select mem_result if mem_reg_write & mem_rd!=0 & mem_rd==rs. Else select wb_result if wb_reg_write & wb_rd!=0 & wb_rd==rs. Else use the registered data.
  - EX/MEM has priority over MEM/WB. x0 is never forwarded.
- SrcA = a_sel ? ex_pc : fwdA. SrcB = b_sel ? ex_imm : fwdB. ex_store_data = fwdB always, regardless of b_sel.
- Latency: 1 cycle from ID capture to EX outputs. Forwarded values pass through combinationally with zero added latency.
- Bubble: Operation=0000 and rd=0, so it is harmless to downstream stages.

Test Plan:
- Reset: assert reset mid-run, asynchronously between edges → ex_valid=0, SrcA=SrcB=0, Operation=0, stall=0 immediately.
- Basic: id add x3,x1,x2 with rs1_data=5, rs2_data=7, op=0010 → next cycle SrcA=5, SrcB=7, Operation=0010, ex_rd=3, ex_valid=1.
- Forward priority: EX rs1=4 with reg data=1; mem_rd=4 & mem_reg_write (mem_result=0xAA); wb_rd=4 & wb_reg_write (wb_result=0xBB) → SrcA=0xAA. Drop mem_reg_write → SrcA=0xBB. Set rd=0 on both sources → SrcA=1.
- Load-use: EX lw x5 (mem_read=1); ID add x6,x5,x1 → stall=1 and the next EX is a bubble (ex_valid=0). The following cycle the add enters EX with stall=0.
- Flush: flush=1 while ID holds a valid sub → next cycle ex_valid=0, ex_reg_write=0, ex_mem_write=0.
- Immediate/PC: id_a_sel=1, id_b_sel=1, pc=0x100, imm=0xFFFFFFFC, rs2 forwarded from WB=0x55 → SrcA=0x100, SrcB=0xFFFFFFFC, ex_store_data=0x55.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage RISC-V core: holds the decoded instruction for EX,
// forwards results from EX/MEM and MEM/WB into the ALU operands, and raises the load-use stall.
module id_ex_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int OPCODE_LENGTH  = 4,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      id_valid,
  input  logic [DATA_WIDTH-1:0]     id_pc,
  input  logic [DATA_WIDTH-1:0]     id_rs1_data,
  input  logic [DATA_WIDTH-1:0]     id_rs2_data,
  input  logic [DATA_WIDTH-1:0]     id_imm,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd,
  input  logic [OPCODE_LENGTH-1:0]  id_alu_op,
  input  logic                      id_a_sel,
  input  logic                      id_b_sel,
  input  logic                      id_reg_write,
  input  logic                      id_mem_read,
  input  logic                      id_mem_write,
  input  logic                      flush,
  input  logic [REG_ADDR_WIDTH-1:0] mem_rd,
  input  logic                      mem_reg_write,
  input  logic [DATA_WIDTH-1:0]     mem_result,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
  input  logic                      wb_reg_write,
  input  logic [DATA_WIDTH-1:0]     wb_result,
  output logic                      stall,
  output logic [DATA_WIDTH-1:0]     SrcA,
  output logic [DATA_WIDTH-1:0]     SrcB,
  output logic [OPCODE_LENGTH-1:0]  Operation,
  output logic                      ex_valid,
  output logic                      ex_reg_write,
  output logic                      ex_mem_read,
  output logic                      ex_mem_write,
  output logic [REG_ADDR_WIDTH-1:0] ex_rd,
  output logic [DATA_WIDTH-1:0]     ex_pc,
  output logic [DATA_WIDTH-1:0]     ex_store_data
);

  logic [DATA_WIDTH-1:0]     ex_rs1_data;
  logic [DATA_WIDTH-1:0]     ex_rs2_data;
  logic [DATA_WIDTH-1:0]     ex_imm;
  logic [REG_ADDR_WIDTH-1:0] ex_rs1;
  logic [REG_ADDR_WIDTH-1:0] ex_rs2;
  logic [OPCODE_LENGTH-1:0]  ex_alu_op;
  logic                      ex_a_sel;
  logic                      ex_b_sel;
  logic [DATA_WIDTH-1:0]     fwd_a;
  logic [DATA_WIDTH-1:0]     fwd_b;

  // Stall handshake: while stall=1 the producer (PC and IF/ID) must hold and re-present the same
  // instruction on the next cycle; this stage loads a bubble meanwhile. rs2 is always compared,
  // so an I-type may stall needlessly, which is harmless.
  always_comb begin
    stall = ex_valid && ex_mem_read && (ex_rd != '0) && id_valid &&
            ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  end

  // Priority: reset > flush > stall > normal capture. A bubble is all zeros (AND, rd=x0).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_rs1_data  <= '0;
      ex_rs2_data  <= '0;
      ex_imm       <= '0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      ex_rd        <= '0;
      ex_alu_op    <= '0;
      ex_a_sel     <= 1'b0;
      ex_b_sel     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
    end else if (flush || stall) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_rs1_data  <= '0;
      ex_rs2_data  <= '0;
      ex_imm       <= '0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      ex_rd        <= '0;
      ex_alu_op    <= '0;
      ex_a_sel     <= 1'b0;
      ex_b_sel     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
    end else begin
      ex_valid     <= id_valid;
      ex_pc        <= id_pc;
      ex_rs1_data  <= id_rs1_data;
      ex_rs2_data  <= id_rs2_data;
      ex_imm       <= id_imm;
      ex_rs1       <= id_rs1;
      ex_rs2       <= id_rs2;
      ex_rd        <= id_rd;
      ex_alu_op    <= id_alu_op;
      ex_a_sel     <= id_a_sel;
      ex_b_sel     <= id_b_sel;
      ex_reg_write <= id_reg_write && id_valid;
      ex_mem_read  <= id_mem_read && id_valid;
      ex_mem_write <= id_mem_write && id_valid;
    end
  end

  // Newest producer (EX/MEM) wins over MEM/WB; x0 is never forwarded.
  always_comb begin
    fwd_a = ex_rs1_data;
    if (mem_reg_write && (mem_rd != '0) && (mem_rd == ex_rs1)) begin
      fwd_a = mem_result;
    end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == ex_rs1)) begin
      fwd_a = wb_result;
    end
  end

  always_comb begin
    fwd_b = ex_rs2_data;
    if (mem_reg_write && (mem_rd != '0) && (mem_rd == ex_rs2)) begin
      fwd_b = mem_result;
    end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == ex_rs2)) begin
      fwd_b = wb_result;
    end
  end

  always_comb begin
    SrcA          = ex_a_sel ? ex_pc : fwd_a;
    SrcB          = ex_b_sel ? ex_imm : fwd_b;
    Operation     = ex_alu_op;
    ex_store_data = fwd_b;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a table of per-cycle vectors plus an asynchronous reset sequence.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]  id_alu_op;
  logic        id_a_sel, id_b_sel, id_reg_write, id_mem_read, id_mem_write;
  logic        flush;
  logic [4:0]  mem_rd, wb_rd;
  logic        mem_reg_write, wb_reg_write;
  logic [31:0] mem_result, wb_result;
  logic        stall;
  logic [31:0] SrcA, SrcB;
  logic [3:0]  Operation;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [4:0]  ex_rd;
  logic [31:0] ex_pc, ex_store_data;

  int checks = 0;
  int errors = 0;

  id_ex_stage #(.DATA_WIDTH(32), .OPCODE_LENGTH(4), .REG_ADDR_WIDTH(5)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_op(id_alu_op),
    .id_a_sel(id_a_sel), .id_b_sel(id_b_sel), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .flush(flush),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
    .stall(stall), .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_rd(ex_rd), .ex_pc(ex_pc), .ex_store_data(ex_store_data)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic valid, flush, a_sel, b_sel, rw, mr, mw;
    logic [3:0]  op;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] pc, rs1d, rs2d, imm;
  } id_t;

  typedef struct {
    logic [4:0]  mem_rd;
    logic        mrw;
    logic [31:0] mem_res;
    logic [4:0]  wb_rd;
    logic        wrw;
    logic [31:0] wb_res;
  } fwd_t;

  typedef struct {
    logic stall, valid, rw, mr, mw;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic [31:0] srca, srcb, store;
  } exp_t;

  typedef struct {
    string name;
    id_t   id;
    fwd_t  fwd;
    exp_t  exp;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_id(input id_t v);
    id_valid = v.valid; flush = v.flush; id_a_sel = v.a_sel; id_b_sel = v.b_sel;
    id_reg_write = v.rw; id_mem_read = v.mr; id_mem_write = v.mw; id_alu_op = v.op;
    id_rs1 = v.rs1; id_rs2 = v.rs2; id_rd = v.rd; id_pc = v.pc;
    id_rs1_data = v.rs1d; id_rs2_data = v.rs2d; id_imm = v.imm;
  endtask

  task automatic drive_fwd(input fwd_t f);
    mem_rd = f.mem_rd; mem_reg_write = f.mrw; mem_result = f.mem_res;
    wb_rd = f.wb_rd; wb_reg_write = f.wrw; wb_result = f.wb_res;
  endtask

  task automatic check_ex(input string tag, input exp_t e);
    chk({tag, ".ex_valid"}, {31'd0, ex_valid}, {31'd0, e.valid});
    chk({tag, ".ex_reg_write"}, {31'd0, ex_reg_write}, {31'd0, e.rw});
    chk({tag, ".ex_mem_read"}, {31'd0, ex_mem_read}, {31'd0, e.mr});
    chk({tag, ".ex_mem_write"}, {31'd0, ex_mem_write}, {31'd0, e.mw});
    chk({tag, ".Operation"}, {28'd0, Operation}, {28'd0, e.op});
    chk({tag, ".ex_rd"}, {27'd0, ex_rd}, {27'd0, e.rd});
    chk({tag, ".SrcA"}, SrcA, e.srca);
    chk({tag, ".SrcB"}, SrcB, e.srcb);
    chk({tag, ".ex_store_data"}, ex_store_data, e.store);
  endtask

  localparam fwd_t FWD_OFF = '{5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0};
  localparam exp_t BUBBLE  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 5'd0, 32'd0, 32'd0, 32'd0};

  initial begin
    // id: valid flush a_sel b_sel rw mr mw op rs1 rs2 rd pc rs1d rs2d imm
    // fwd: mem_rd mrw mem_res wb_rd wrw wb_res
    // exp: stall(pre-edge) valid rw mr mw op rd srca srcb store (post-edge)
    vecs[0]  = '{"add_x3", '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,4'h2,5'd1,5'd2,5'd3,32'h0,32'd5,32'd7,32'd0},
                 FWD_OFF, '{1'b0,1'b1,1'b1,1'b0,1'b0,4'h2,5'd3,32'd5,32'd7,32'd7}};
    vecs[1]  = '{"lw_x5", '{1'b1,1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,4'h2,5'd2,5'd0,5'd5,32'h4,32'h20,32'h11,32'd8},
                 FWD_OFF, '{1'b0,1'b1,1'b1,1'b1,1'b0,4'h2,5'd5,32'h20,32'd8,32'h11}};
    vecs[2]  = '{"loaduse_stall", '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,4'h2,5'd5,5'd1,5'd6,32'h8,32'h99,32'd3,32'd0},
                 FWD_OFF, '{1'b1,1'b0,1'b0,1'b0,1'b0,4'h0,5'd0,32'd0,32'd0,32'd0}};
    vecs[3]  = '{"loaduse_retry", '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,4'h2,5'd5,5'd1,5'd6,32'h8,32'h99,32'd3,32'd0},
                 '{5'd5,1'b1,32'h1234,5'd0,1'b0,32'd0}, '{1'b0,1'b1,1'b1,1'b0,1'b0,4'h2,5'd6,32'h1234,32'd3,32'd3}};
    vecs[4]  = '{"flush_sub", '{1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,4'h6,5'd6,5'd6,5'd7,32'hC,32'd1,32'd1,32'd0},
                 FWD_OFF, BUBBLE};
    vecs[5]  = '{"pc_imm", '{1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,4'h2,5'd1,5'd9,5'd0,32'h100,32'h7,32'h0,32'hFFFFFFFC},
                 '{5'd0,1'b0,32'd0,5'd9,1'b1,32'h55}, '{1'b0,1'b1,1'b0,1'b0,1'b1,4'h2,5'd0,32'h100,32'hFFFFFFFC,32'h55}};
    vecs[6]  = '{"fwd_mem_prio", '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,4'h7,5'd4,5'd0,5'd8,32'h10,32'd1,32'd0,32'd0},
                 '{5'd4,1'b1,32'hAA,5'd4,1'b1,32'hBB}, '{1'b0,1'b1,1'b1,1'b0,1'b0,4'h7,5'd8,32'hAA,32'd0,32'd0}};
    vecs[7]  = '{"fwd_wb", '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,4'h7,5'd4,5'd0,5'd8,32'h10,32'd1,32'd0,32'd0},
                 '{5'd4,1'b0,32'hAA,5'd4,1'b1,32'hBB}, '{1'b0,1'b1,1'b1,1'b0,1'b0,4'h7,5'd8,32'hBB,32'd0,32'd0}};
    vecs[8]  = '{"fwd_x0_none", '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,4'h7,5'd4,5'd0,5'd8,32'h10,32'd1,32'd0,32'd0},
                 '{5'd0,1'b1,32'hAA,5'd0,1'b1,32'hBB}, '{1'b0,1'b1,1'b1,1'b0,1'b0,4'h7,5'd8,32'd1,32'd0,32'd0}};
    vecs[9]  = '{"invalid_id", '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1,4'h0,5'd10,5'd11,5'd0,32'h20,32'h42,32'h43,32'd0},
                 FWD_OFF, '{1'b0,1'b0,1'b0,1'b0,1'b0,4'h0,5'd0,32'h42,32'h43,32'h43}};
    vecs[10] = '{"lw_x12", '{1'b1,1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,4'h2,5'd0,5'd0,5'd12,32'h24,32'd0,32'd0,32'd4},
                 FWD_OFF, '{1'b0,1'b1,1'b1,1'b1,1'b0,4'h2,5'd12,32'd0,32'd4,32'd0}};
    vecs[11] = '{"flush_and_stall", '{1'b1,1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,4'h2,5'd1,5'd12,5'd13,32'h28,32'd1,32'd2,32'd5},
                 FWD_OFF, '{1'b1,1'b0,1'b0,1'b0,1'b0,4'h0,5'd0,32'd0,32'd0,32'd0}};
    vecs[12] = '{"lw_x0", '{1'b1,1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,4'h2,5'd0,5'd0,5'd0,32'h2C,32'd0,32'd0,32'd4},
                 FWD_OFF, '{1'b0,1'b1,1'b1,1'b1,1'b0,4'h2,5'd0,32'd0,32'd4,32'd0}};
    vecs[13] = '{"no_stall_on_x0", '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,4'h2,5'd0,5'd0,5'd13,32'h30,32'd0,32'd0,32'd0},
                 '{5'd0,1'b1,32'hDEAD,5'd0,1'b0,32'd0}, '{1'b0,1'b1,1'b1,1'b0,1'b0,4'h2,5'd13,32'd0,32'd0,32'd0}};

    reset = 1'b1;
    drive_id('{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'h0,5'd0,5'd0,5'd0,32'd0,32'd0,32'd0,32'd0});
    drive_fwd(FWD_OFF);
    repeat (2) @(negedge clk);
    check_ex("reset", BUBBLE);
    chk("reset.stall", {31'd0, stall}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      drive_id(vecs[i].id);
      drive_fwd(vecs[i].fwd);
      #1;
      chk({vecs[i].name, ".stall"}, {31'd0, stall}, {31'd0, vecs[i].exp.stall});
      @(posedge clk);
      #1;
      check_ex(vecs[i].name, vecs[i].exp);
      @(negedge clk);
    end

    // Asynchronous reset between edges while a load-use stall is pending.
    drive_fwd(FWD_OFF);
    drive_id('{1'b1,1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,4'h2,5'd2,5'd0,5'd5,32'h40,32'h20,32'd0,32'd8});
    @(posedge clk);
    @(negedge clk);
    drive_id('{1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,4'h2,5'd5,5'd1,5'd6,32'h44,32'h99,32'd3,32'd0});
    #1;
    chk("pre_reset.stall", {31'd0, stall}, 32'd1);
    #1;
    reset = 1'b1;
    #1;
    check_ex("async_reset", BUBBLE);
    chk("async_reset.stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_ex("after_reset", '{1'b0,1'b1,1'b1,1'b0,1'b0,4'h2,5'd6,32'h99,32'd3,32'd3});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, got no end expected end");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

endmodule
